// File: rtl/execute_stage_pipe.sv
// RV32/RV64 execute stage with EX/MEM register, branch/jump resolution and a radix-2 iterative multiplier.
// Optional `EXEC_STATS_EN adds redirect and stall event counters.
module execute_stage_pipe #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_e,
  input  logic            flush_e_i,
  input  logic            mem_stall_i,
  input  logic            reg_write_e,
  input  logic            mem_write_e,
  input  logic            branch_e,
  input  logic            jump_e,
  input  logic            jalr_e,
  input  logic            alu_src_e,
  input  logic [1:0]      result_src_e,
  input  logic [1:0]      fwd_a_e,
  input  logic [1:0]      fwd_b_e,
  input  logic [3:0]      alu_ctrl_e,
  input  logic [2:0]      funct3_e,
  input  logic [RA_W-1:0] rd_e,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] imm_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] result_w,
  output logic            stall_e_o,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic            valid_m,
  output logic            reg_write_m,
  output logic            mem_write_m,
  output logic [1:0]      result_src_m,
  output logic [RA_W-1:0] rd_m,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] pc_plus4_m
`ifdef EXEC_STATS_EN
  ,
  output logic [31:0]     stat_taken_o,
  output logic [31:0]     stat_stall_o
`endif
);

  localparam int SW = $clog2(XLEN);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic            valid_m_q, valid_m_d, reg_write_m_q, reg_write_m_d, mem_write_m_q, mem_write_m_d;
  logic [1:0]      result_src_m_q, result_src_m_d;
  logic [RA_W-1:0] rd_m_q, rd_m_d;
  logic [XLEN-1:0] alu_result_m_q, alu_result_m_d, write_data_m_q, write_data_m_d;
  logic [XLEN-1:0] pc_plus4_m_q, pc_plus4_m_d;

  logic [1:0]        state_q, state_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic              neg_q, neg_d, hi_q, hi_d;

  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_res, ex_res, jalr_sum, mul_res;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN:0]   step_sum;
  logic [2*XLEN-1:0] prod_fixed;
  logic [SW-1:0]   shamt;
  logic            cond, taken, mul_op, a_sgn, b_sgn, a_neg, b_neg, mul_start, retire;

  always_comb begin
    case (fwd_a_e)
      2'b01:   src_a = result_w;
      2'b10:   src_a = alu_result_m_q;
      default: src_a = rd1_e;
    endcase
    case (fwd_b_e)
      2'b01:   fwd_b = result_w;
      2'b10:   fwd_b = alu_result_m_q;
      default: fwd_b = rd2_e;
    endcase
    src_b = alu_src_e ? imm_e : fwd_b;
    shamt = src_b[SW-1:0];
  end

  always_comb begin
    alu_res = '0;
    case (alu_ctrl_e)
      4'b0000: alu_res = src_a + src_b;
      4'b0001: alu_res = src_a - src_b;
      4'b0010: alu_res = src_a & src_b;
      4'b0011: alu_res = src_a | src_b;
      4'b0100: alu_res = src_a ^ src_b;
      4'b0101: alu_res = src_a << shamt;
      4'b0110: alu_res = src_a >> shamt;
      4'b0111: alu_res = $unsigned($signed(src_a) >>> shamt);
      4'b1000: alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'b1001: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      4'b1010: alu_res = src_b;
      default: alu_res = '0;
    endcase
  end

  // Branch compares always use the register operand, never the immediate.
  always_comb begin
    cond = 1'b0;
    case (funct3_e)
      3'b000:  cond = (src_a == fwd_b);
      3'b001:  cond = (src_a != fwd_b);
      3'b100:  cond = ($signed(src_a) < $signed(fwd_b));
      3'b101:  cond = ($signed(src_a) >= $signed(fwd_b));
      3'b110:  cond = (src_a < fwd_b);
      3'b111:  cond = (src_a >= fwd_b);
      default: cond = 1'b0;
    endcase
    taken    = jump_e | (branch_e & cond);
    jalr_sum = src_a + imm_e;
    pc_target_e = jalr_e ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_e + imm_e);
  end

  always_comb begin
    mul_op = (alu_ctrl_e[3:2] == 2'b11);
    a_sgn  = (alu_ctrl_e != 4'b1111);
    b_sgn  = (alu_ctrl_e == 4'b1100) || (alu_ctrl_e == 4'b1101);
    a_neg  = a_sgn & src_a[XLEN-1];
    b_neg  = b_sgn & fwd_b[XLEN-1];
    abs_a  = a_neg ? (~src_a + 1'b1) : src_a;
    abs_b  = b_neg ? (~fwd_b + 1'b1) : fwd_b;
    mul_start = (state_q == ST_IDLE) & valid_e & mul_op & ~flush_e_i;
    stall_e_o = mem_stall_i | mul_start | (state_q == ST_RUN) |
                ((state_q == ST_DONE) & mem_stall_i);
    pc_src_e  = valid_e & ~flush_e_i & ~stall_e_o & taken;
    step_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? mcand_q : {XLEN{1'b0}})};
    prod_fixed = neg_q ? (~prod_q + 1'b1) : prod_q;
    mul_res    = hi_q ? prod_fixed[2*XLEN-1:XLEN] : prod_fixed[XLEN-1:0];
  end

  // Magnitudes are multiplied unsigned; the sign is reapplied to the full product in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    if (flush_e_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (mul_start) begin
          state_d = ST_RUN;
          cnt_d   = SW'(XLEN-1);
          mcand_d = abs_a;
          prod_d  = {{XLEN{1'b0}}, abs_b};
          neg_d   = a_neg ^ b_neg;
          hi_d    = (alu_ctrl_e != 4'b1100);
        end
        ST_RUN: begin
          prod_d = {step_sum, prod_q[XLEN-1:1]};
          cnt_d  = cnt_q - SW'(1);
          if (cnt_q == '0) state_d = ST_DONE;
        end
        ST_DONE: if (!mem_stall_i) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    retire = valid_e & ~flush_e_i & ~stall_e_o;
    ex_res = (state_q == ST_DONE) ? mul_res : alu_res;
    valid_m_d      = valid_m_q;
    reg_write_m_d  = reg_write_m_q;
    mem_write_m_d  = mem_write_m_q;
    result_src_m_d = result_src_m_q;
    rd_m_d         = rd_m_q;
    alu_result_m_d = alu_result_m_q;
    write_data_m_d = write_data_m_q;
    pc_plus4_m_d   = pc_plus4_m_q;
    if (flush_e_i || (!mem_stall_i && !retire)) begin
      valid_m_d     = 1'b0;
      reg_write_m_d = 1'b0;
      mem_write_m_d = 1'b0;
    end else if (!mem_stall_i) begin
      valid_m_d      = 1'b1;
      reg_write_m_d  = reg_write_e;
      mem_write_m_d  = mem_write_e;
      result_src_m_d = result_src_e;
      rd_m_d         = rd_e;
      alu_result_m_d = ex_res;
      write_data_m_d = fwd_b;
      pc_plus4_m_d   = pc_e + XLEN'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_m_q      <= 1'b0;
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      result_src_m_q <= '0;
      rd_m_q         <= '0;
      alu_result_m_q <= '0;
      write_data_m_q <= '0;
      pc_plus4_m_q   <= '0;
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      prod_q         <= '0;
      mcand_q        <= '0;
      neg_q          <= 1'b0;
      hi_q           <= 1'b0;
    end else begin
      valid_m_q      <= valid_m_d;
      reg_write_m_q  <= reg_write_m_d;
      mem_write_m_q  <= mem_write_m_d;
      result_src_m_q <= result_src_m_d;
      rd_m_q         <= rd_m_d;
      alu_result_m_q <= alu_result_m_d;
      write_data_m_q <= write_data_m_d;
      pc_plus4_m_q   <= pc_plus4_m_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      prod_q         <= prod_d;
      mcand_q        <= mcand_d;
      neg_q          <= neg_d;
      hi_q           <= hi_d;
    end
  end

  assign valid_m      = valid_m_q;
  assign reg_write_m  = reg_write_m_q;
  assign mem_write_m  = mem_write_m_q;
  assign result_src_m = result_src_m_q;
  assign rd_m         = rd_m_q;
  assign alu_result_m = alu_result_m_q;
  assign write_data_m = write_data_m_q;
  assign pc_plus4_m   = pc_plus4_m_q;

`ifdef EXEC_STATS_EN
  logic [31:0] stat_taken_q, stat_taken_d, stat_stall_q, stat_stall_d;

  always_comb begin
    stat_taken_d = stat_taken_q + {31'd0, pc_src_e};
    stat_stall_d = stat_stall_q + {31'd0, stall_e_o};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_taken_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_taken_q <= stat_taken_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_taken_o = stat_taken_q;
  assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_execute_stage_pipe.sv
// Directed bench for execute_stage_pipe (XLEN=32): a cycle-level reference model checked every
// negedge, plus literal expectations from hand-worked examples.
module tb_execute_stage_pipe;
  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam int MUL_STALL = XLEN + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid_e, flush_e_i, mem_stall_i, reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e;
  logic [1:0] result_src_e, fwd_a_e, fwd_b_e;
  logic [3:0] alu_ctrl_e;
  logic [2:0] funct3_e;
  logic [RA_W-1:0] rd_e;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e, result_w;
  logic stall_e_o, pc_src_e, valid_m, reg_write_m, mem_write_m;
  logic [31:0] pc_target_e, alu_result_m, write_data_m, pc_plus4_m;
  logic [1:0] result_src_m;
  logic [RA_W-1:0] rd_m;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  execute_stage_pipe #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .valid_e(valid_e), .flush_e_i(flush_e_i), .mem_stall_i(mem_stall_i),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .branch_e(branch_e), .jump_e(jump_e),
    .jalr_e(jalr_e), .alu_src_e(alu_src_e), .result_src_e(result_src_e), .fwd_a_e(fwd_a_e),
    .fwd_b_e(fwd_b_e), .alu_ctrl_e(alu_ctrl_e), .funct3_e(funct3_e), .rd_e(rd_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e), .result_w(result_w),
    .stall_e_o(stall_e_o), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .valid_m(valid_m),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
    .rd_m(rd_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return $unsigned($signed(a) >>> b[4:0]);
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mul_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = (op != 4'hF) ? longint'($signed(a)) : longint'({32'd0, a});
    sb = (op == 4'hC || op == 4'hD) ? longint'($signed(b)) : longint'({32'd0, b});
    p = 64'(sa * sb);
    return (op == 4'hC) ? p[31:0] : p[63:32];
  endfunction

  function automatic bit br_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Expected EX/MEM contents and multiply progress (age = cycles since issue).
  logic e_valid, e_rw, e_mw;
  logic [1:0] e_rs;
  logic [RA_W-1:0] e_rd;
  logic [31:0] e_alu, e_wd, e_pc4, mb_res;
  bit mb_busy;
  int mb_age;

  logic [31:0] m_a, m_b, m_srcb, m_target;
  logic m_mul, m_stall, m_pcsrc, m_retire;

  always_comb begin
    m_a = (fwd_a_e == 2'b01) ? result_w : (fwd_a_e == 2'b10) ? e_alu : rd1_e;
    m_b = (fwd_b_e == 2'b01) ? result_w : (fwd_b_e == 2'b10) ? e_alu : rd2_e;
    m_srcb = alu_src_e ? imm_e : m_b;
    m_mul = (alu_ctrl_e[3:2] == 2'b11);
    m_stall = mem_stall_i | (!mb_busy & valid_e & m_mul & !flush_e_i) |
              (mb_busy & (mb_age <= XLEN)) | (mb_busy & (mb_age == XLEN + 1) & mem_stall_i);
    m_pcsrc = valid_e & !flush_e_i & !m_stall & (jump_e | (branch_e & br_model(funct3_e, m_a, m_b)));
    m_target = jalr_e ? ((m_a + imm_e) & ~32'h1) : (pc_e + imm_e);
    m_retire = valid_e & !flush_e_i & !m_stall;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      {e_valid, e_rw, e_mw} <= 3'b000;
      e_rs <= '0; e_rd <= '0; e_alu <= '0; e_wd <= '0; e_pc4 <= '0;
      mb_busy <= 1'b0; mb_age <= 0;
    end else if (flush_e_i) begin
      mb_busy <= 1'b0;
      {e_valid, e_rw, e_mw} <= 3'b000;
    end else begin
      if (!mb_busy && valid_e && m_mul) begin
        mb_busy <= 1'b1; mb_age <= 1; mb_res <= mul_model(alu_ctrl_e, m_a, m_b);
      end else if (mb_busy && mb_age <= XLEN) begin
        mb_age <= mb_age + 1;
      end else if (mb_busy && !mem_stall_i) begin
        mb_busy <= 1'b0;
      end
      if (!mem_stall_i) begin
        if (m_retire) begin
          {e_valid, e_rw, e_mw} <= {1'b1, reg_write_e, mem_write_e};
          e_rs <= result_src_e; e_rd <= rd_e; e_wd <= m_b; e_pc4 <= pc_e + 32'd4;
          e_alu <= mb_busy ? mb_res : alu_model(alu_ctrl_e, m_a, m_srcb);
        end else begin
          {e_valid, e_rw, e_mw} <= 3'b000;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_e_o", 32'(stall_e_o), 32'(m_stall));
      chk("pc_src_e", 32'(pc_src_e), 32'(m_pcsrc));
      chk("pc_target_e", pc_target_e, m_target);
      chk("valid_m", 32'(valid_m), 32'(e_valid));
      chk("reg_write_m", 32'(reg_write_m), 32'(e_rw));
      chk("mem_write_m", 32'(mem_write_m), 32'(e_mw));
      if (e_valid) begin
        chk("result_src_m", 32'(result_src_m), 32'(e_rs));
        chk("rd_m", 32'(rd_m), 32'(e_rd));
        chk("alu_result_m", alu_result_m, e_alu);
        chk("write_data_m", write_data_m, e_wd);
        chk("pc_plus4_m", pc_plus4_m, e_pc4);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_e = 0; flush_e_i = 0; mem_stall_i = 0; reg_write_e = 0; mem_write_e = 0;
    branch_e = 0; jump_e = 0; jalr_e = 0; alu_src_e = 0; result_src_e = 0;
    fwd_a_e = 0; fwd_b_e = 0; alu_ctrl_e = 0; funct3_e = 0; rd_e = 0;
    rd1_e = 0; rd2_e = 0; imm_e = 0; pc_e = 32'h40; result_w = 32'h0BAD_0001;
  endtask

  task automatic op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] im, input logic asrc);
    idle_inputs();
    valid_e = 1; reg_write_e = 1; rd_e = 5'd7; alu_ctrl_e = ctrl;
    rd1_e = a; rd2_e = b; imm_e = im; alu_src_e = asrc;
  endtask

  task automatic run_mul(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    int n;
    op(ctrl, a, b, 32'd0, 1'b0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall_e_o) n++;
      else break;
    end
    chk("mul_stall_cycles", 32'(n), 32'(MUL_STALL));
    tick();
    idle_inputs();
    chk("mul_result", alu_result_m, exp);
    chk("mul_valid_m", 32'(valid_m), 32'd1);
    $display("mul op=%h a=%h b=%h -> %h (stall %0d cycles)", ctrl, a, b, alu_result_m, n);
  endtask

  logic [31:0] vec_a [2] = '{32'h8000_0005, 32'h1234_5678};
  logic [31:0] vec_b [2] = '{32'h0000_0003, 32'hFFFF_FF84};
  logic [2:0]  br_f3 [6] = '{3'b000, 3'b001, 3'b101, 3'b111, 3'b010, 3'b011};

  initial begin
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    chk("reset_valid_m", 32'(valid_m), 32'd0);
    chk("reset_alu_result_m", alu_result_m, 32'd0);
    chk("reset_pc_plus4_m", pc_plus4_m, 32'd0);
    chk("reset_stall", 32'(stall_e_o), 32'd0);
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // forwarded ADD: operand A comes from alu_result_m (7), plus imm 3
    op(4'd0, 32'd7, 32'd0, 32'd0, 1'b0);
    tick();
    op(4'd0, 32'd5, 32'd0, 32'd3, 1'b1);
    fwd_a_e = 2'b10;
    tick();
    chk("fwd_add_result", alu_result_m, 32'd10);
    chk("fwd_add_valid", 32'(valid_m), 32'd1);
    $display("fwd add -> %h", alu_result_m);

    // signed vs unsigned less-than branch
    op(4'd1, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0);
    branch_e = 1; reg_write_e = 0; pc_e = 32'h100; funct3_e = 3'b100;
    #1;
    chk("blt_taken", 32'(pc_src_e), 32'd1);
    chk("blt_target", pc_target_e, 32'h120);
    $display("blt taken=%b target=%h", pc_src_e, pc_target_e);
    tick();
    funct3_e = 3'b110;
    #1;
    chk("bltu_not_taken", 32'(pc_src_e), 32'd0);
    $display("bltu taken=%b", pc_src_e);
    tick();
    foreach (br_f3[i]) begin
      funct3_e = br_f3[i];
      rd2_e = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'd1;
      tick();
      $display("branch f3=%b rd1=%h rd2=%h", br_f3[i], rd1_e, rd2_e);
    end

    // JALR: target clears bit 0; link value travels in pc_plus4_m
    op(4'd0, 32'h1003, 32'd0, 32'd4, 1'b1);
    jump_e = 1; jalr_e = 1; result_src_e = 2'b10; pc_e = 32'h200;
    #1;
    chk("jalr_taken", 32'(pc_src_e), 32'd1);
    chk("jalr_target", pc_target_e, 32'h1006);
    tick();
    chk("jalr_pc_plus4", pc_plus4_m, 32'h204);
    chk("jalr_result_src", 32'(result_src_m), 32'd2);
    $display("jalr target=1006 pc_plus4_m=%h", pc_plus4_m);

    // single-cycle ALU sweep, checked by the model each cycle
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < 2; j++) begin
        op(4'(k), vec_a[j], vec_b[j], 32'h0000_0011, 1'(j));
        mem_write_e = 1'(k % 2);
        tick();
        $display("alu op=%0d a=%h b=%h -> %h", k, vec_a[j], vec_b[j], alu_result_m);
      end
    end
    idle_inputs();
    tick();

    // multiplies
    run_mul(4'hD, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF);
    run_mul(4'hC, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
    run_mul(4'hE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mul(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // mem stall held for three cycles of DONE
    op(4'hC, 32'd6, 32'd7, 32'd0, 1'b0);
    repeat (MUL_STALL) tick();
    mem_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_stall_high", 32'(stall_e_o), 32'd1);
      chk("done_hold_valid", 32'(valid_m), 32'd0);
    end
    mem_stall_i = 1'b0;
    #1;
    chk("done_release_stall", 32'(stall_e_o), 32'd0);
    tick();
    idle_inputs();
    chk("done_stall_result", alu_result_m, 32'd42);
    chk("done_stall_valid", 32'(valid_m), 32'd1);
    $display("mul under mem stall -> %h", alu_result_m);

    // flush mid-run, then an ADD retires the following cycle
    op(4'hC, 32'd6, 32'd7, 32'd0, 1'b0);
    repeat (10) tick();
    flush_e_i = 1'b1;
    tick();
    chk("flush_valid_m", 32'(valid_m), 32'd0);
    op(4'd0, 32'd2, 32'd3, 32'd0, 1'b0);
    #1;
    chk("flush_idle_no_stall", 32'(stall_e_o), 32'd0);
    tick();
    chk("post_flush_add", alu_result_m, 32'd5);
    chk("post_flush_valid", 32'(valid_m), 32'd1);
    $display("flush mid-run, next add -> %h", alu_result_m);

    // asynchronous reset in the middle of a multiply
    op(4'hF, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid_m", 32'(valid_m), 32'd0);
    chk("arst_reg_write_m", 32'(reg_write_m), 32'd0);
    chk("arst_alu_result_m", alu_result_m, 32'd0);
    chk("arst_rd_m", 32'(rd_m), 32'd0);
    chk("arst_pc_plus4_m", pc_plus4_m, 32'd0);
    tick();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("arst_stall_after", 32'(stall_e_o), 32'd0);
    $display("async reset mid-run done");
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_stage_pipe.md
Name: execute_stage_pipe

Overview:
Parametrised RV32/RV64 execute stage with its EX/MEM pipeline register.
- Adds to the single-cycle execute design: full branch-condition set, JAL/JALR, valid/stall/flush pipeline control, and an iterative radix-2 multiplier (MUL/MULH/MULHSU/MULHU).
- Sits between the ID/EX register and the memory stage.
- The hazard unit consumes stall_e_o and pc_src_e.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
RA_W, 5, register-address width.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
valid_e  in  1  instruction present in EX
flush_e_i  in  1  kill EX instruction (priority over everything except rst)
mem_stall_i  in  1  hold EX/MEM register
reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e  in  1 each  controls
result_src_e  in  2  00 ALU, 01 mem, 10 PC+4
fwd_a_e, fwd_b_e  in  2 each  00 regfile, 01 result_w, 10 alu_result_m, 11 regfile
alu_ctrl_e  in  4  operation
funct3_e  in  3  branch condition
rd_e  in  RA_W  destination register
rd1_e, rd2_e, imm_e, pc_e, result_w  in  XLEN each
stall_e_o  out  1  EX cannot retire this cycle
pc_src_e  out  1  redirect fetch
pc_target_e  out  XLEN  branch/jump target
valid_m, reg_write_m, mem_write_m  out  1 each  registered
result_src_m  out  2  registered
rd_m  out  RA_W  registered
alu_result_m, write_data_m, pc_plus4_m  out  XLEN each  registered

Behaviour:
- Reset (async): all *_m outputs = 0; multiplier FSM = IDLE; counter = 0.
- Operand selection:
  - SrcA = fwd_a mux output.
  - fwdB = fwd_b mux output.
  - SrcB = alu_src_e ? imm_e : fwdB.
  - write_data = fwdB.
- alu_ctrl encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA (shift amount = SrcB[$clog2(XLEN)-1:0]).
  - 1000 SLT, 1001 SLTU, 1010 pass SrcB.
  - 1011 result 0.
  - 1100 MUL, 1101 MULH, 1110 MULHSU, 1111 MULHU (multi-cycle).
- Branch taken per funct3:
  - 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - 010/011 never taken.
  - Compare uses SrcA vs fwdB.
- Jumps and target:
  - taken = jump_e | (branch_e & cond).
  - pc_target_e = jalr_e ? ((SrcA+imm_e) & ~1) : pc_e+imm_e.
  - pc_src_e = valid_e & ~flush_e_i & ~stall_e_o & taken.
- Single-cycle ops: EX/MEM loads at the clock edge when ~mem_stall_i. Latency is 1 cycle.
- Multiplier FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE: on valid & mul op & ~flush, capture |SrcA|, |fwdB| and result sign (per op signedness) -> RUN. Counter = XLEN-1.
  - RUN: one shift-add step per cycle; at counter 0 -> DONE.
  - DONE: apply sign fix; select low (MUL) or high XLEN bits. When ~mem_stall_i, load EX/MEM -> IDLE. Otherwise remain in DONE.
- stall_e_o = mem_stall_i | (IDLE & valid_e & mul & ~flush_e_i) | RUN | (DONE & mem_stall_i).
- Multiply timing:
  - A multiply issued in cycle C holds stall_e_o high for cycles C..C+XLEN.
  - The result is written at the end of cycle C+XLEN+1 when unstalled.
  - Captured operands ignore later forwarding changes.
- Bubble: when EX does not retire and ~mem_stall_i, EX/MEM loads valid/reg_write/mem_write = 0; other fields are don't-care. Applies to flush, ~valid_e and multiply-busy cycles.
- mem_stall_i: every EX/MEM field holds its value.
- Flush: flush_e_i in any FSM state -> IDLE and a bubble, overriding mem_stall_i for valid/write bits.
- Reset mid-RUN aborts the multiply with no output.
- pc_plus4_m = pc_e + 4, registered with the EX/MEM fields.
- All arithmetic is modulo 2^XLEN.

Optional Feature:
EXEC_STATS_EN
- Defined: adds outputs stat_taken_o[31:0] and stat_stall_o[31:0].
  - stat_taken_o counts cycles with pc_src_e = 1.
  - stat_stall_o counts cycles with stat_stall_o's trigger stall_e_o = 1.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Forwarded ADD: rd1_e=5, fwd_a=10, alu_result_m=7, imm=3, alu_src=1 -> next cycle alu_result_m=10, valid_m=1.
2. Signed vs unsigned branch: rd1=0xFFFFFFFF, rd2=1, pc=0x100, imm=0x20.
   - BLT -> pc_src_e=1, target 0x120.
   - BLTU -> pc_src_e=0.
3. JALR: rd1=0x1003, imm=4, result_src=10, pc=0x200 -> target 0x1006, pc_plus4_m=0x204.
4. MULH -3*5 (XLEN=32) -> stall_e_o high 33 cycles, alu_result_m=0xFFFFFFFF. Repeat with MUL -> 0xFFFFFFF1.
5. Stall and flush around a multiply:
   - mem_stall_i high 3 cycles during DONE -> EX/MEM holds, result appears after release.
   - flush mid-RUN -> valid_m=0, FSM IDLE, next ADD retires 1 cycle later.
6. Async rst asserted mid-RUN -> all *_m = 0 immediately, stall_e_o=0 after release.
